// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one external combinational adder
// between NREQ requesters. Each grant latches an operand pair, drives the
// shared adder from registers for one cycle, then presents the captured sum
// on a single response channel tagged with the requester id.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  operand width; sums are WIDTH+1 bits
//   IDW    requester id width (>= clog2(NREQ))
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   req_valid[NREQ]        per-requester operand valid
//   req_ready[NREQ]        per-requester accept (one-hot or zero, IDLE only)
//   req_a, req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   add_a, add_b           registered operands to the shared adder
//   add_out                shared adder result (carry in MSB)
//   resp_valid/resp_ready  response handshake
//   resp_sum, resp_id      captured sum and issuing requester id
//   op_count               completed-response counter (only with
//                          ADDER_ARBITER_STATS_EN defined)
//
// Optional feature macro: ADDER_ARBITER_STATS_EN
module adder_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    input  logic [WIDTH:0]          add_out,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [WIDTH:0]          resp_sum,
    output logic [IDW-1:0]          resp_id
`ifdef ADDER_ARBITER_STATS_EN
    ,
    output logic [7:0]              op_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan_idx;
    logic [NREQ-1:0]  grant;
    logic             grant_found;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Round-robin search: first valid requester at ptr, ptr+1, ... modulo NREQ
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((32'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
        if (grant_found) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Accept is only offered while idle; at most one op is ever in flight
    assign req_ready = (state == S_IDLE) ? grant : '0;

    // Operand select for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Datapath registers: operands, id, captured result, round-robin pointer.
    // add_a/add_b change only on a grant so the shared adder sees stable inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            add_a    <= '0;
            add_b    <= '0;
            id_q     <= '0;
            ptr      <= '0;
            resp_sum <= '0;
            resp_id  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        add_a <= sel_a;
                        add_b <= sel_b;
                        id_q  <= grant_id;
                    end
                end
                S_CALC: begin
                    resp_sum <= add_out;
                    resp_id  <= id_q;
                end
                S_RESP: begin
                    // Pointer moves past the requester just served
                    if (resp_ready) begin
                        ptr <= IDW'((32'(id_q) + 32'd1) % NREQ);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid = (state == S_RESP);

`ifdef ADDER_ARBITER_STATS_EN
    // Completed-response counter, wraps at 8 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (resp_valid && resp_ready) begin
            op_count <= op_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one combinational WIDTH-bit adder (external instance, carry-out in MSB) between NREQ requesters.
- Each requester presents an operand pair with valid/ready. The arbiter grants round-robin, drives the shared adder from registered operands, captures the sum and returns it on a single response channel tagged with the requester id.
- Sits between requesting datapath blocks and the shared Adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 2, operand width; sum is WIDTH+1 bits
- IDW, 2, width of requester id (>= clog2(NREQ))

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester accept, at most one bit high
- req_a  input  NREQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand b, same packing
- add_a  output  WIDTH  to shared adder input a
- add_b  output  WIDTH  to shared adder input b
- add_out  input  WIDTH+1  from shared adder output
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_sum  output  WIDTH+1  captured sum
- resp_id  output  IDW  index of requester that issued the operation

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, rr pointer=0.
  - add_a, add_b, resp_sum, resp_id = 0; resp_valid=0; req_ready=0.
  - Reset mid-operation drops any in-flight op; no response is produced for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req_ready is combinational. One-hot on the first i with req_valid[i]=1, searching pointer, pointer+1, ..., wrapping modulo NREQ. All zero if no valid.
  - On the edge when a grant exists: latch the granted req_a/req_b into the operand registers, latch id, then go to CALC. The transfer counts as complete in that cycle.
  - With no valid, stay in IDLE.
- CALC:
  - add_a/add_b come from the operand registers (always registered, never combinational from the req inputs).
  - At the end of the cycle: resp_sum <= add_out, resp_id <= latched id, go to RESP.
  - req_ready=0.
- RESP:
  - resp_valid=1. resp_sum and resp_id are held stable while resp_valid=1 and resp_ready=0.
  - On the edge with resp_ready=1: go to IDLE and set pointer <= (id+1) mod NREQ. For id=NREQ-1 it wraps to 0.
  - req_ready=0 throughout.
- Latency: accept at edge T, resp_valid high during the cycle after edge T+1. Minimum 3 cycles per operation, so at most one op in flight.
- Fairness: a continuously valid requester is granted within NREQ operations.
- Arithmetic: no truncation. Max sum (2^WIDTH-1)*2 fits in WIDTH+1 bits.
- Simultaneous events:
  - A requester dropping req_valid in the same cycle it is not granted has no effect.
  - The operands a requester holds stable while waiting are the ones latched when it is granted.
  - req_valid changing during CALC/RESP is ignored until IDLE.
- add_a/add_b keep their last values after an op; they change only on a grant.

Optional Feature:
- Macro ADDER_ARBITER_STATS_EN.
- When defined, add output port op_count (8 bits):
  - Reset to 0.
  - Increments by 1 on each resp_valid & resp_ready handshake.
  - Wraps 255 -> 0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Single op: reset, then req_valid=0001, a0=3, b0=2 -> req_ready=0001 for one cycle; resp_valid 2 cycles later with resp_sum=5, resp_id=0; with resp_ready=1 the FSM returns to IDLE.
- Round-robin: all four valid, operands a_i=i, b_i=1, resp_ready tied 1 -> responses in id order 0,1,2,3,0 with sums 1,2,3,4,1; exactly one req_ready bit per grant.
- Wrap/pointer: after granting id=3, assert req_valid=1001 -> id 0 granted next (pointer wrapped); then with 1001 still valid, id 3 granted.
- Backpressure: resp_ready=0 for 5 cycles during RESP with sum 6 -> resp_valid, resp_sum=6, resp_id held stable; req_ready stays 0 even with all requests valid; release -> IDLE.
- Reset mid-op: rst_n=0 during CALC -> next cycle resp_valid=0, add_a=add_b=0, pointer=0; the dropped op is never returned; a subsequent req from id 2 alone is granted normally.
- Stats (macro defined): 257 completed handshakes -> op_count=1; with resp_ready=0, op_count does not advance.
